t_logic_pipe: RTL
=================

Name: t_logic_pipe

Overview:
- Parametrised, pipelined, multi-lane successor of the 5-input/2-output "t" benchmark function.
- WIDTH independent bit lanes share one valid/ready stream.
- Results pass through a 2-stage pipeline, then a DEPTH-entry output FIFO.
- Credit-based flow control: no accepted transaction is ever dropped under backpressure.

Parameters:
- WIDTH, 8, number of parallel bit lanes per operand.
- DEPTH, 4, output FIFO entries; power of two, at least 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block can accept this cycle.
- pi0  input  WIDTH  operand 0, lane-wise.
- pi1  input  WIDTH  operand 1, lane-wise.
- pi2  input  WIDTH  operand 2, lane-wise.
- pi3  input  WIDTH  operand 3, lane-wise.
- pi4  input  WIDTH  operand 4, lane-wise.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer takes head this cycle.
- po0  output  WIDTH  result 0 at FIFO head.
- po1  output  WIDTH  result 1 at FIFO head.
- level  output  clog2(DEPTH+1)  current FIFO occupancy.
- stat_acc  output  16  accepted-transaction count (optional feature).
- stat_stall  output  16  stall-cycle count (optional feature).

Behaviour:
- Lane function, per bit i:
  - n9 = pi2 & pi3
  - po0 = (pi0 & pi2) | (pi1 & ~n9)
  - po1 = (pi1 | pi4) & ~n9
- Accept = in_valid & in_ready.
- Stage 1, loaded on accept: registers n8 = pi0&pi2, n9, pi1 and pi4; sets s1_v. Otherwise s1_v clears.
- Stage 2: unconditionally takes stage 1 each cycle and computes po0/po1 into registers; s2_v <= s1_v.
- FIFO write: when s2_v is set, at the next edge.
- Latency: accepted in cycle k -> out_valid and data at head in cycle k+3, provided the FIFO was empty.
- The pipeline never stalls. Backpressure is applied only at input: in_ready = (level + s1_v + s2_v) < DEPTH.
- in_ready is combinational from state only. It has no path from in_valid or out_ready.
- A pop in the same cycle does not release a credit early.
- Pop on out_valid & out_ready. po0/po1 show the head entry; they hold stable while out_valid & ~out_ready.
- When out_valid=0, po0/po1 are don't-care but are reset to 0.
- Simultaneous FIFO write and pop: level unchanged and data order preserved.
- Pointers wrap modulo DEPTH.
- Full FIFO: the credit rule guarantees no write occurs when level=DEPTH. The bench asserts this.
- Empty FIFO with out_ready=1: no effect.
- Reset values:
  - in_ready=1 the cycle after reset deasserts (during reset, in_ready=0)
  - out_valid=0, level=0, po0=0, po1=0
  - s1_v=0, s2_v=0, FIFO pointers=0
  - stat_acc=0, stat_stall=0
- Reset mid-operation discards all in-flight and buffered results with no output pulse. The first accept after reset follows normal latency.
- Ordering: strict FIFO, one result per accepted input.

Optional Feature:
- Macro: T_LOGIC_PIPE_STATS_EN.
- When defined:
  - stat_acc increments on each accept.
  - stat_stall increments on each cycle with in_valid & ~in_ready.
  - Both are 16-bit, saturate at 16'hFFFF and clear on rst.
- When undefined: the counters are not built, and stat_acc/stat_stall are tied to 0.

Test Plan:
- Basic, WIDTH=4, all stimulus in cycle 0:
  - Stimulus: pi0=1111, pi1=0101, pi2=0011, pi3=0001, pi4=1000, out_ready=1.
  - Required: out_valid in cycle 3 with po0=0111, po1=1100, level=1 then 0.
- Backpressure fill, DEPTH=4:
  - Stimulus: out_ready=0, in_valid held high.
  - Required: exactly 4 accepts, after which in_ready=0. level reaches 4 and never exceeds it. With stats enabled, stat_stall counts the stalled cycles.
- Drain order:
  - Stimulus: from the full state, raise out_ready=1 and keep in_valid high with distinct pi0 values.
  - Required: results pop in acceptance order, one per cycle. Throughput reaches 1/cycle once steady state is reached.
- Simultaneous push/pop:
  - Stimulus: level=2, with a FIFO write and a pop in the same cycle.
  - Required: level stays 2 and the head advances correctly.
- Reset mid-flight:
  - Stimulus: assert rst for 1 cycle with s1_v=1, s2_v=1 and level=3.
  - Required: next cycle out_valid=0 and level=0. A subsequent input appears 3 cycles after its accept.
- Stats saturation (macro on):
  - Stimulus: preload via 65 540 accepts.
  - Required: stat_acc=16'hFFFF and it holds there.

Source files
------------

// File: rtl/t_logic_pipe.sv
// t_logic_pipe: WIDTH-lane pipelined "t" function (2 stages) feeding a DEPTH-entry FIFO.
// Credit flow control at the input; statistics counters are built when T_LOGIC_PIPE_STATS_EN is defined.
module t_logic_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             pi0,
   input  logic [WIDTH-1:0]             pi1,
   input  logic [WIDTH-1:0]             pi2,
   input  logic [WIDTH-1:0]             pi3,
   input  logic [WIDTH-1:0]             pi4,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             po0,
   output logic [WIDTH-1:0]             po1,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [15:0]                  stat_acc,
   output logic [15:0]                  stat_stall
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] r0;
      logic [WIDTH-1:0] r1;
   } result_t;

   logic             accept;
   logic             push;
   logic             pop;
   logic [LW:0]      credits;

   logic             s1_v;
   logic [WIDTH-1:0] s1_n8;
   logic [WIDTH-1:0] s1_n9;
   logic [WIDTH-1:0] s1_p1;
   logic [WIDTH-1:0] s1_p4;

   logic             s2_v;
   result_t          s2_res;

   result_t          mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    count;

   // Every result already in flight holds a credit, so the FIFO can never overflow
   // even though the pipeline itself never stalls. Pops free credits one cycle late.
   always_comb begin
      credits   = (LW+1)'(count) + (LW+1)'(s1_v) + (LW+1)'(s2_v);
      in_ready  = ~rst & (credits < (LW+1)'(DEPTH));
      accept    = in_valid & in_ready;
      out_valid = (count != '0);
      pop       = out_valid & out_ready;
      push      = s2_v;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         s1_v <= accept;
         s2_v <= s1_v;
      end
   end

   // Datapath registers carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_n8 <= pi0 & pi2;
         s1_n9 <= pi2 & pi3;
         s1_p1 <= pi1;
         s1_p4 <= pi4;
      end
   end

   always_ff @(posedge clk) begin
      s2_res.r0 <= s1_n8 | (s1_p1 & ~s1_n9);
      s2_res.r1 <= (s1_p1 | s1_p4) & ~s1_n9;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage array is not reset; occupancy is tracked by count and the output is masked when empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s2_res;
   end

   always_comb begin
      po0   = out_valid ? mem[rd_ptr].r0 : '0;
      po1   = out_valid ? mem[rd_ptr].r1 : '0;
      level = count;
   end

`ifdef T_LOGIC_PIPE_STATS_EN
   logic [15:0] acc_cnt;
   logic [15:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (accept && acc_cnt != 16'hFFFF)
            acc_cnt <= acc_cnt + 16'd1;
         if (in_valid && !in_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign stat_acc   = acc_cnt;
   assign stat_stall = stall_cnt;
`else
   assign stat_acc   = 16'h0000;
   assign stat_stall = 16'h0000;
`endif

endmodule
